hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage 16-bit core.
- Drives the stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the PC write enable.
- Watches ID-stage source operands, EX/MEM destinations, branch resolution in ID, cache-miss indications and HLT.
- Sequences multi-cycle stalls, branch-operand waits and the halt drain.

Parameters:
- DRAIN_CYCLES, 3: cycles after HLT leaves ID before `halted` asserts (range 1..7).
- CNT_W, 16: width of the optional performance counters.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous reset, active-low
- ID_rs, ID_rt  in  4 each  source registers of the ID instruction
- ID_uses_rs, ID_uses_rt  in  1 each  source actually read
- ID_Branch  in  1  conditional branch (B/BR) in ID, reads flags
- ID_BranchReg  in  1  BR in ID, reads rs in ID
- ID_taken  in  1  branch resolved taken in ID (valid only when not stalled)
- ID_Halt  in  1  HLT decoded in ID
- EX_rd  in  4  EX destination register
- EX_RegWrite, EX_MemRead, EX_FLAG_Enable  in  1 each
- MEM_rd  in  4  MEM destination register
- MEM_MemRead  in  1
- imem_miss, dmem_miss  in  1 each  cache busy, held high until fill completes
- pc_wen  out  1
- IFID_stall, IFID_flush, IDEX_stall, IDEX_flush, EXMEM_stall, MEMWB_flush  out  1 each
- halted  out  1  registered; core fully drained
- stall_cnt, flush_cnt  out  CNT_W each  performance counters

Behaviour:
- State register is updated on posedge clk. Outputs are a Mealy function of state and current inputs, except `halted`, which is registered.
- Reset: rst_n = 0 at posedge sets state to RUN, `halted` to 0 and both counters to 0. While rst_n is low, outputs are pc_wen = 0, all stalls = 0 and all flushes = 1.
- States: RUN, BR_WAIT, DMEM_WAIT, DRAIN, HALTED.
- Hazard definitions (r0 never matches):
  - lu = EX_MemRead & (EX_rd == ID_rs & ID_uses_rs | EX_rd == ID_rt & ID_uses_rt).
  - fl = ID_Branch & EX_FLAG_Enable.
  - brx = ID_BranchReg & EX_RegWrite & EX_rd == ID_rs.
  - brm = ID_BranchReg & MEM_MemRead & MEM_rd == ID_rs.
- RUN priority, highest first:
  1. dmem_miss: go to DMEM_WAIT. This cycle: pc_wen = 0, IFID_stall = IDEX_stall = EXMEM_stall = 1, MEMWB_flush = 1.
  2. lu | fl | brx | brm: pc_wen = 0, IFID_stall = 1, IDEX_flush = 1 (one bubble). If brx & EX_MemRead, go to BR_WAIT (second bubble).
  3. imem_miss: pc_wen = 0, IFID_flush = 1.
  4. ID_taken: IFID_flush = 1, pc_wen = 1.
  5. ID_Halt: pc_wen = 0, IFID_flush = 1, load drain counter with DRAIN_CYCLES, go to DRAIN.
  6. Otherwise: pc_wen = 1, all stalls and flushes = 0.
- BR_WAIT: repeat the case-2 outputs for exactly one cycle, then return to RUN. A dmem_miss arriving here takes precedence and goes to DMEM_WAIT; BR_WAIT is re-evaluated by the RUN hazard equations on exit.
- DMEM_WAIT: hold the case-1 outputs while dmem_miss = 1. In the first cycle with dmem_miss = 0, return to RUN; the outputs that cycle are the RUN outputs.
- DRAIN:
  - pc_wen = 0, IFID_flush = 1.
  - The counter decrements each cycle that dmem_miss = 0; dmem_miss freezes it and applies the case-1 stalls.
  - When it reaches 0, go to HALTED and set `halted` = 1 on the same edge.
- HALTED: terminal until reset. pc_wen = 0, IFID_flush = IDEX_flush = 1.
- A stall and a flush are never both asserted on the same register. Stall wins: a flush requested by a taken branch while IFID_stall = 1 is suppressed, because ID_taken is invalid while stalled.
- A reset mid-DMEM_WAIT or mid-DRAIN returns to RUN with no residual state.

Optional Feature:
- Macro HAZ_PERF_EN.
- Defined: stall_cnt increments in every cycle with pc_wen = 0 outside reset and HALTED; flush_cnt increments in every cycle with IFID_flush = 1 or IDEX_flush = 1. Both saturate at all-ones and clear on reset.
- Undefined: both counters are absent and the ports are tied to 0.

Decomposition:
- Package hazard_pkg holds:
  - the state enum;
  - the constant REG_ZERO = 4'd0;
  - a struct bundling the six stall/flush outputs.
- Sub-module hazard_detect: purely combinational lu/fl/brx/brm comparators, instantiated once.

Test Plan:
- lw r3 in EX (EX_MemRead = 1, EX_rd = 3), add using r3 in ID -> one cycle of pc_wen = 0, IFID_stall = 1, IDEX_flush = 1; next cycle all 0.
- lw r5 in EX, BR r5 in ID -> two consecutive bubble cycles (RUN, then BR_WAIT), then normal.
- dmem_miss high for 4 cycles together with a load-use hazard -> 4 cycles of EXMEM_stall = 1 with IDEX_flush = 0; the load-use bubble appears afterwards.
- ID_taken = 1 with no hazard -> IFID_flush = 1, pc_wen = 1 for 1 cycle; with EX_FLAG_Enable = 1 the flush is delayed one cycle.
- ID_Halt with DRAIN_CYCLES = 3 and dmem_miss for 2 cycles mid-drain -> `halted` rises 5 cycles after HLT and stays; rst_n low clears it.
- With HAZ_PERF_EN, hold a stall for 70000 cycles -> stall_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, the
// stall/flush control bundle and register-compare helpers.
package hazard_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_BR_WAIT,
    ST_DMEM_WAIT,
    ST_DRAIN,
    ST_HALTED
  } hz_state_t;

  localparam logic [3:0] REG_ZERO = 4'd0;

  typedef struct packed {
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_flush;
    logic exmem_stall;
    logic memwb_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_IDLE   = '{default: 1'b0};
  localparam pipe_ctrl_t CTRL_DMEM   = '{ifid_stall: 1'b1, idex_stall: 1'b1, exmem_stall: 1'b1,
                                         memwb_flush: 1'b1, default: 1'b0};
  localparam pipe_ctrl_t CTRL_BUBBLE = '{ifid_stall: 1'b1, idex_flush: 1'b1, default: 1'b0};
  localparam pipe_ctrl_t CTRL_IFLUSH = '{ifid_flush: 1'b1, default: 1'b0};
  localparam pipe_ctrl_t CTRL_HALT   = '{ifid_flush: 1'b1, idex_flush: 1'b1, default: 1'b0};
  localparam pipe_ctrl_t CTRL_RESET  = '{ifid_flush: 1'b1, idex_flush: 1'b1, memwb_flush: 1'b1,
                                         default: 1'b0};

  // r0 is hardwired to zero, so it can never carry a dependency.
  function automatic logic reg_match(input logic [3:0] dst, input logic [3:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

  // A stalled register keeps its contents; a flush on it would be meaningless.
  function automatic pipe_ctrl_t stall_wins(input pipe_ctrl_t c);
    pipe_ctrl_t r;
    r = c;
    r.ifid_flush = c.ifid_flush & ~c.ifid_stall;
    r.idex_flush = c.idex_flush & ~c.idex_stall;
    return r;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational data/flag hazard comparators between the ID stage and the
// EX/MEM destinations: load-use, flag dependency and branch-register waits.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [3:0] ID_rs,
  input  logic [3:0] ID_rt,
  input  logic       ID_uses_rs,
  input  logic       ID_uses_rt,
  input  logic       ID_Branch,
  input  logic       ID_BranchReg,
  input  logic [3:0] EX_rd,
  input  logic       EX_RegWrite,
  input  logic       EX_MemRead,
  input  logic       EX_FLAG_Enable,
  input  logic [3:0] MEM_rd,
  input  logic       MEM_MemRead,
  output logic       lu,
  output logic       fl,
  output logic       brx,
  output logic       brm
);

  logic [3:0] src [2];
  logic [1:0] src_used;
  logic [1:0] ex_hit;

  assign src[0]   = ID_rs;
  assign src[1]   = ID_rt;
  assign src_used = {ID_uses_rt, ID_uses_rs};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign ex_hit[gi] = src_used[gi] & reg_match(EX_rd, src[gi]);
    end
  endgenerate

  assign lu  = EX_MemRead & (|ex_hit);
  assign fl  = ID_Branch & EX_FLAG_Enable;
  assign brx = ID_BranchReg & EX_RegWrite & reg_match(EX_rd, ID_rs);
  assign brm = ID_BranchReg & MEM_MemRead & reg_match(MEM_rd, ID_rs);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: stalls, flushes, PC enable and halt drain.
// Define HAZ_PERF_EN to build the saturating stall/flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       ID_rs,
  input  logic [3:0]       ID_rt,
  input  logic             ID_uses_rs,
  input  logic             ID_uses_rt,
  input  logic             ID_Branch,
  input  logic             ID_BranchReg,
  input  logic             ID_taken,
  input  logic             ID_Halt,
  input  logic [3:0]       EX_rd,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic             EX_FLAG_Enable,
  input  logic [3:0]       MEM_rd,
  input  logic             MEM_MemRead,
  input  logic             imem_miss,
  input  logic             dmem_miss,
  output logic             pc_wen,
  output logic             IFID_stall,
  output logic             IFID_flush,
  output logic             IDEX_stall,
  output logic             IDEX_flush,
  output logic             EXMEM_stall,
  output logic             MEMWB_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES);

  hz_state_t  state_reg, state_next;
  logic [2:0] drain_reg, drain_next;
  logic       halted_reg, halted_next;

  logic       lu, fl, brx, brm;
  logic       any_haz;

  logic       run_pc_wen;
  pipe_ctrl_t run_ctrl;
  hz_state_t  run_state;
  logic       run_load_drain;

  logic       pc_wen_c;
  pipe_ctrl_t ctrl_raw, ctrl_c;

  hazard_detect u_detect (
    .ID_rs         (ID_rs),
    .ID_rt         (ID_rt),
    .ID_uses_rs    (ID_uses_rs),
    .ID_uses_rt    (ID_uses_rt),
    .ID_Branch     (ID_Branch),
    .ID_BranchReg  (ID_BranchReg),
    .EX_rd         (EX_rd),
    .EX_RegWrite   (EX_RegWrite),
    .EX_MemRead    (EX_MemRead),
    .EX_FLAG_Enable(EX_FLAG_Enable),
    .MEM_rd        (MEM_rd),
    .MEM_MemRead   (MEM_MemRead),
    .lu            (lu),
    .fl            (fl),
    .brx           (brx),
    .brm           (brm)
  );

  assign any_haz = lu | fl | brx | brm;

  // Decision taken in RUN; also reused on the cycle DMEM_WAIT releases.
  always_comb begin
    run_pc_wen     = 1'b1;
    run_ctrl       = CTRL_IDLE;
    run_state      = ST_RUN;
    run_load_drain = 1'b0;
    if (dmem_miss) begin
      run_pc_wen = 1'b0;
      run_ctrl   = CTRL_DMEM;
      run_state  = ST_DMEM_WAIT;
    end else if (any_haz) begin
      run_pc_wen = 1'b0;
      run_ctrl   = CTRL_BUBBLE;
      // A BR waiting on a load in EX needs the value from MEM/WB: two bubbles.
      if (brx && EX_MemRead) begin
        run_state = ST_BR_WAIT;
      end
    end else if (imem_miss) begin
      run_pc_wen = 1'b0;
      run_ctrl   = CTRL_IFLUSH;
    end else if (ID_taken) begin
      run_ctrl = CTRL_IFLUSH;
    end else if (ID_Halt) begin
      run_pc_wen     = 1'b0;
      run_ctrl       = CTRL_IFLUSH;
      run_state      = ST_DRAIN;
      run_load_drain = 1'b1;
    end
  end

  always_comb begin
    state_next  = state_reg;
    drain_next  = drain_reg;
    halted_next = halted_reg;
    pc_wen_c    = 1'b0;
    ctrl_raw    = CTRL_IDLE;
    case (state_reg)
      ST_RUN, ST_DMEM_WAIT: begin
        pc_wen_c   = run_pc_wen;
        ctrl_raw   = run_ctrl;
        state_next = run_state;
        if (run_load_drain) begin
          drain_next = DRAIN_INIT;
        end
      end
      ST_BR_WAIT: begin
        if (dmem_miss) begin
          ctrl_raw   = CTRL_DMEM;
          state_next = ST_DMEM_WAIT;
        end else begin
          ctrl_raw   = CTRL_BUBBLE;
          state_next = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (dmem_miss) begin
          ctrl_raw = CTRL_DMEM;
        end else begin
          ctrl_raw   = CTRL_IFLUSH;
          drain_next = drain_reg - 3'd1;
          if (drain_reg <= 3'd1) begin
            drain_next  = 3'd0;
            state_next  = ST_HALTED;
            halted_next = 1'b1;
          end
        end
      end
      ST_HALTED: begin
        ctrl_raw = CTRL_HALT;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase

    ctrl_c = stall_wins(ctrl_raw);
    if (!rst_n) begin
      pc_wen_c = 1'b0;
      ctrl_c   = CTRL_RESET;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ST_RUN;
      drain_reg  <= 3'd0;
      halted_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      drain_reg  <= drain_next;
      halted_reg <= halted_next;
    end
  end

  assign pc_wen      = pc_wen_c;
  assign IFID_stall  = ctrl_c.ifid_stall;
  assign IFID_flush  = ctrl_c.ifid_flush;
  assign IDEX_stall  = ctrl_c.idex_stall;
  assign IDEX_flush  = ctrl_c.idex_flush;
  assign EXMEM_stall = ctrl_c.exmem_stall;
  assign MEMWB_flush = ctrl_c.memwb_flush;
  assign halted      = halted_reg;

`ifdef HAZ_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (!pc_wen_c && (state_reg != ST_HALTED) && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
      end
      if ((ctrl_c.ifid_flush || ctrl_c.idex_flush) && (flush_cnt_reg != '1)) begin
        flush_cnt_reg <= flush_cnt_reg + CNT_ONE;
      end
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; outputs are sampled on the
// falling edge and compared to hand-computed control patterns.
module tb_hazard_ctrl;

  // {pc_wen, IFID_stall, IFID_flush, IDEX_stall, IDEX_flush, EXMEM_stall, MEMWB_flush}
  localparam logic [6:0] C_NORMAL = 7'b1000000;
  localparam logic [6:0] C_BUBBLE = 7'b0100100;
  localparam logic [6:0] C_DMEM   = 7'b0101011;
  localparam logic [6:0] C_TAKEN  = 7'b1010000;
  localparam logic [6:0] C_IFLUSH = 7'b0010000;
  localparam logic [6:0] C_HALT   = 7'b0010100;
  localparam logic [6:0] C_RESET  = 7'b0010101;

`ifdef HAZ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ID_rs, ID_rt, EX_rd, MEM_rd;
  logic        ID_uses_rs, ID_uses_rt, ID_Branch, ID_BranchReg, ID_taken, ID_Halt;
  logic        EX_RegWrite, EX_MemRead, EX_FLAG_Enable, MEM_MemRead;
  logic        imem_miss, dmem_miss;
  logic        pc_wen, IFID_stall, IFID_flush, IDEX_stall, IDEX_flush, EXMEM_stall, MEMWB_flush;
  logic        halted;
  logic [15:0] stall_cnt, flush_cnt;
  logic [6:0]  ctrl_obs;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  assign ctrl_obs = {pc_wen, IFID_stall, IFID_flush, IDEX_stall, IDEX_flush, EXMEM_stall, MEMWB_flush};

  hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
    .ID_Branch(ID_Branch), .ID_BranchReg(ID_BranchReg), .ID_taken(ID_taken), .ID_Halt(ID_Halt),
    .EX_rd(EX_rd), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
    .EX_FLAG_Enable(EX_FLAG_Enable), .MEM_rd(MEM_rd), .MEM_MemRead(MEM_MemRead),
    .imem_miss(imem_miss), .dmem_miss(dmem_miss),
    .pc_wen(pc_wen), .IFID_stall(IFID_stall), .IFID_flush(IFID_flush),
    .IDEX_stall(IDEX_stall), .IDEX_flush(IDEX_flush), .EXMEM_stall(EXMEM_stall),
    .MEMWB_flush(MEMWB_flush), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    ID_rs = 4'd0; ID_rt = 4'd0; ID_uses_rs = 1'b0; ID_uses_rt = 1'b0;
    ID_Branch = 1'b0; ID_BranchReg = 1'b0; ID_taken = 1'b0; ID_Halt = 1'b0;
    EX_rd = 4'd0; EX_RegWrite = 1'b0; EX_MemRead = 1'b0; EX_FLAG_Enable = 1'b0;
    MEM_rd = 4'd0; MEM_MemRead = 1'b0; imem_miss = 1'b0; dmem_miss = 1'b0;
  endtask

  // One clock cycle: inputs already driven, check at negedge, advance past posedge.
  task automatic cyc(input string tag, input logic [6:0] exp_ctrl, input logic exp_halt);
    @(negedge clk);
    $display("%0t %-10s ctrl=%b halted=%b", $time, tag, ctrl_obs, halted);
    check({tag, "_ctrl"}, 32'(ctrl_obs), 32'(exp_ctrl));
    check({tag, "_halt"}, 32'(halted), 32'(exp_halt));
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc("rst", C_RESET, 1'b0);
    @(negedge clk);
    check("rst_scnt", 32'(stall_cnt), 32'd0);
    check("rst_fcnt", 32'(flush_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc("idle", C_NORMAL, 1'b0);

    // load-use: lw r3 in EX, add reads r3
    EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_rd = 4'd3; ID_rt = 4'd3; ID_uses_rt = 1'b1;
    cyc("lu", C_BUBBLE, 1'b0);
    clear_inputs();
    cyc("lu_after", C_NORMAL, 1'b0);

    // r0 never matches
    EX_MemRead = 1'b1; EX_rd = 4'd0; ID_rs = 4'd0; ID_uses_rs = 1'b1;
    cyc("lu_r0", C_NORMAL, 1'b0);
    clear_inputs();

    // lw r5 in EX, BR r5 in ID: RUN bubble then BR_WAIT bubble
    EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_rd = 4'd5;
    ID_Branch = 1'b1; ID_BranchReg = 1'b1; ID_rs = 4'd5; ID_uses_rs = 1'b1;
    cyc("brw1", C_BUBBLE, 1'b0);
    clear_inputs();
    cyc("brw2", C_BUBBLE, 1'b0);
    cyc("brw_done", C_NORMAL, 1'b0);

    // BR on ALU result in EX: single bubble only
    EX_RegWrite = 1'b1; EX_rd = 4'd7; ID_BranchReg = 1'b1; ID_rs = 4'd7;
    cyc("brx", C_BUBBLE, 1'b0);
    clear_inputs();
    cyc("brx_done", C_NORMAL, 1'b0);

    // dmem_miss for 4 cycles with load-use pending
    EX_MemRead = 1'b1; EX_rd = 4'd3; ID_rs = 4'd3; ID_uses_rs = 1'b1; dmem_miss = 1'b1;
    for (int i = 0; i < 4; i++) cyc($sformatf("dmiss%0d", i), C_DMEM, 1'b0);
    dmem_miss = 1'b0;
    cyc("dmiss_lu", C_BUBBLE, 1'b0);
    clear_inputs();
    cyc("dmiss_done", C_NORMAL, 1'b0);

    // taken branch, then taken branch behind a flag hazard
    ID_Branch = 1'b1; ID_taken = 1'b1;
    cyc("taken", C_TAKEN, 1'b0);
    EX_FLAG_Enable = 1'b1;
    cyc("taken_fl", C_BUBBLE, 1'b0);
    EX_FLAG_Enable = 1'b0;
    cyc("taken_late", C_TAKEN, 1'b0);
    clear_inputs();

    imem_miss = 1'b1;
    cyc("imiss", C_IFLUSH, 1'b0);
    clear_inputs();

    // HLT, two-cycle dmem_miss during drain, then 3 drain cycles
    ID_Halt = 1'b1;
    cyc("hlt", C_IFLUSH, 1'b0);
    clear_inputs();
    dmem_miss = 1'b1;
    cyc("drain_m0", C_DMEM, 1'b0);
    cyc("drain_m1", C_DMEM, 1'b0);
    dmem_miss = 1'b0;
    for (int i = 0; i < 3; i++) cyc($sformatf("drain%0d", i), C_IFLUSH, 1'b0);
    cyc("halted0", C_HALT, 1'b1);
    ID_taken = 1'b1; dmem_miss = 1'b1;
    cyc("halted1", C_HALT, 1'b1);
    clear_inputs();

    // reset out of HALTED
    rst_n = 1'b0;
    cyc("rst_h0", C_RESET, 1'b1);
    cyc("rst_h1", C_RESET, 1'b0);
    rst_n = 1'b1;
    cyc("post_rst", C_NORMAL, 1'b0);

    // reset mid-DRAIN leaves no residue
    ID_Halt = 1'b1;
    cyc("hlt2", C_IFLUSH, 1'b0);
    clear_inputs();
    cyc("drain2", C_IFLUSH, 1'b0);
    rst_n = 1'b0;
    cyc("rst_d", C_RESET, 1'b0);
    rst_n = 1'b1;
    cyc("post_rst_d", C_NORMAL, 1'b0);

    // counters: fresh reset, then a long imem_miss stall
    rst_n = 1'b0;
    cyc("rst_c", C_RESET, 1'b0);
    rst_n = 1'b1;
    cyc("cnt_idle", C_NORMAL, 1'b0);
    @(negedge clk);
    check("cnt_zero_s", 32'(stall_cnt), 32'd0);
    check("cnt_zero_f", 32'(flush_cnt), 32'd0);
    imem_miss = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("cnt5_s", 32'(stall_cnt), PERF ? 32'd5 : 32'd0);
    check("cnt5_f", 32'(flush_cnt), PERF ? 32'd5 : 32'd0);
    repeat (70000) @(posedge clk);
    @(negedge clk);
    check("cnt_sat_s", 32'(stall_cnt), PERF ? 32'h0000FFFF : 32'd0);
    check("cnt_sat_f", 32'(flush_cnt), PERF ? 32'h0000FFFF : 32'd0);
    check("cnt_sat_ctrl", 32'(ctrl_obs), 32'(C_IFLUSH));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
